dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's dmem interface. It accepts load/store requests, returns read data and the byte-lane mask, and holds the core stalled until the access completes.
- Contains a byte-writable word RAM with a configurable access latency.
- Sits between the single-cycle datapath/control path and on-chip data storage.
- Drives the lane mask the datapath uses for load extraction, and the stall the control path uses to freeze the PC.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; must be a power of two.
- BASE_ADDR, 32'h0001_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 2: cycles from request acceptance to the response; legal range 1..15.

Ports:
- clk  input  1  clock; everything is rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- io_req_valid  input  1  request present.
- io_req_ready  output  1  responder can accept a request this cycle.
- io_req_addr  input  32  byte address.
- io_req_wen  input  1  1 = store, 0 = load.
- io_req_size  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- io_req_wdata  input  32  store data, already shifted into its byte lanes.
- io_resp_valid  output  1  one-cycle pulse marking response completion.
- io_resp_rdata  output  32  raw aligned word read; no extraction is performed.
- io_resp_mask  output  4  active byte lanes of the access.
- io_resp_err  output  1  access was out of range or misaligned (see Optional Feature).
- io_stall  output  1  core must hold its PC and register-file write.

Behaviour:
- Clocking/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state = IDLE, io_req_ready = 1, io_resp_valid = 0, io_resp_rdata = 0, io_resp_mask = 0, io_resp_err = 0, io_stall = 0. RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - io_req_ready = 1.
  - io_stall = io_req_valid (combinational).
  - On io_req_valid: latch addr, wen, size, wdata and the computed mask.
  - Load counter with LATENCY-1. Go to WAIT, or directly to RESP if LATENCY == 1.
- WAIT:
  - io_req_ready = 0, io_stall = 1.
  - Decrement the counter. When it reaches 1, go to RESP.
  - The RAM access (read, or masked write) happens on the edge entering RESP.
- RESP:
  - io_resp_valid = 1, io_req_ready = 0, io_stall = 0.
  - Next state is always IDLE.
  - Response appears exactly LATENCY cycles after the acceptance edge.
  - Back-to-back requests are separated by at least one IDLE cycle.
- Mask generation:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 if addr[1] = 0, else 4'b1100.
  - Word: 4'b1111.
- io_resp_mask / io_resp_rdata / io_resp_err are registered. They hold their values after RESP until the next response.
- Stores:
  - Only lanes whose mask bit is set are written.
  - io_resp_rdata for a store returns the pre-write word.
- Range check: if (addr - BASE_ADDR) >= DEPTH_WORDS*4, then io_resp_err = 1, the write is suppressed, and io_resp_rdata = 0. Timing is unchanged.
- Word index = (addr - BASE_ADDR) >> 2. Address wrap-around is not permitted.
- Reset asserted in WAIT: the pending request is dropped, no write occurs, and state returns to IDLE.
- io_req_valid in WAIT/RESP: ignored, because io_req_ready = 0. The requester holds the request.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0] = 1, or word access with addr[1:0] != 0, sets io_resp_err = 1.
  - The write is suppressed, and io_resp_mask = 0 for that response.
- Undefined:
  - Low address bits below the access size are ignored. A half uses addr[1] only; a word is forced to lanes 4'b1111.
  - io_resp_err reflects only the range check.

Decomposition:
- Shared package/header dmem_consts.vh:
  - DMEM_SIZE_B = 0, DMEM_SIZE_H = 1, DMEM_SIZE_W = 2, DMEM_SIZE_WIDTH = 2.
  - State encodings DMEM_ST_IDLE, DMEM_ST_WAIT, DMEM_ST_RESP.
- Sub-module dmem_sram_bank:
  - Synchronous single-port RAM, DEPTH_WORDS x 32.
  - 4-bit byte write enable; read-before-write, returning old data.
  - The responder FSM instantiates it once.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs reach reset values immediately; io_req_ready = 1.
- Word store then load, LATENCY = 2: SW 0xDEADBEEF @ 0x00010008 -> resp_valid 2 cycles after acceptance, mask 1111, stall high for 2 cycles. LW @ 0x00010008 -> rdata 0xDEADBEEF.
- Byte store: SB addr 0x00010009, wdata 0x0000AB00, onto a word holding 0xDEADBEEF -> mask 0010; subsequent LW returns 0xDEADABEF.
- Half load at addr 0x0001000A -> mask 1100, rdata is the full word, err 0.
- Out of range: LW @ 0x00020000 with DEPTH_WORDS = 1024 -> err 1, rdata 0, latency unchanged. A SW to the same address leaves the RAM unmodified.
- Reset in WAIT (LATENCY = 3): SW 0x12345678 @ 0x00010000, assert rst the cycle after acceptance -> no resp_valid; a later LW @ 0x00010000 returns the old contents.
- With DMEM_MISALIGN_TRAP_EN: LH @ 0x00010001 -> err 1, mask 0000. A SW @ 0x00010002 writes nothing.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants, request payload and lane-mask helpers for the dmem responder.
package dmem_responder_pkg;

   localparam int unsigned DMEM_SIZE_WIDTH = 2;
   localparam logic [DMEM_SIZE_WIDTH-1:0] DMEM_SIZE_B = 2'd0;
   localparam logic [DMEM_SIZE_WIDTH-1:0] DMEM_SIZE_H = 2'd1;
   localparam logic [DMEM_SIZE_WIDTH-1:0] DMEM_SIZE_W = 2'd2;

   localparam logic [1:0] DMEM_ST_IDLE = 2'd0;
   localparam logic [1:0] DMEM_ST_WAIT = 2'd1;
   localparam logic [1:0] DMEM_ST_RESP = 2'd2;

   localparam int unsigned DMEM_CNT_WIDTH = 4;

   typedef struct packed {
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic        range_err;
      logic        mis_err;
   } dmem_req_t;

   // Active byte lanes; size 3 is reserved and behaves as a word.
   function automatic logic [3:0] dmem_lane_mask(input logic [DMEM_SIZE_WIDTH-1:0] size,
                                                 input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         DMEM_SIZE_B: m = 4'b0001 << addr_lo;
         DMEM_SIZE_H: m = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:     m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic dmem_misaligned(input logic [DMEM_SIZE_WIDTH-1:0] size,
                                            input logic [1:0] addr_lo);
      logic mis;
      case (size)
         DMEM_SIZE_B: mis = 1'b0;
         DMEM_SIZE_H: mis = addr_lo[0];
         default:     mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Single-port synchronous word RAM with byte write enables, read-before-write.
// The read register is reset and can be forced to zero; the array itself is not reset.
module dmem_sram_bank #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          zero,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (en) begin
         rdata_d = zero ? 32'h0 : mem[addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= 32'h0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Array update; the read above samples the pre-write word on the same edge.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, stalls the core for LATENCY cycles, then responds.
// Build option DMEM_MISALIGN_TRAP_EN flags misaligned half/word accesses as errors.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       io_req_valid,
   output logic                       io_req_ready,
   input  logic [31:0]                io_req_addr,
   input  logic                       io_req_wen,
   input  logic [DMEM_SIZE_WIDTH-1:0] io_req_size,
   input  logic [31:0]                io_req_wdata,
   output logic                       io_resp_valid,
   output logic [31:0]                io_resp_rdata,
   output logic [3:0]                 io_resp_mask,
   output logic                       io_resp_err,
   output logic                       io_stall
);

   localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [DMEM_CNT_WIDTH-1:0] CNT_INIT = DMEM_CNT_WIDTH'(LATENCY - 1);

   logic [1:0]                state_q, state_d;
   logic [DMEM_CNT_WIDTH-1:0] cnt_q, cnt_d;
   dmem_req_t                 req_q, req_d, req_c, cur_c;
   logic [AW-1:0]             idx_q, idx_d, idx_c, cur_idx_c;
   logic [31:0]               off_c;
   logic                      ready_q, ready_d;
   logic                      resp_valid_q, resp_valid_d;
   logic [3:0]                resp_mask_q, resp_mask_d;
   logic                      resp_err_q, resp_err_d;
   logic                      ram_en_c;
   logic [3:0]                ram_we_c;
   logic [31:0]               ram_rdata;

   // Decode of the request currently on the bus.
   always_comb begin
      req_c           = '0;
      off_c           = io_req_addr - BASE_ADDR;
      idx_c           = off_c[AW+1:2];
      req_c.wen       = io_req_wen;
      req_c.wdata     = io_req_wdata;
      req_c.range_err = (off_c >= SPAN_BYTES);
`ifdef DMEM_MISALIGN_TRAP_EN
      req_c.mis_err   = dmem_misaligned(io_req_size, io_req_addr[1:0]);
      req_c.mask      = req_c.mis_err ? 4'b0000 : dmem_lane_mask(io_req_size, io_req_addr[1:0]);
`else
      req_c.mis_err   = 1'b0;
      req_c.mask      = dmem_lane_mask(io_req_size, io_req_addr[1:0]);
`endif
   end

   // Next state, request capture and RAM strobe; cur_c is the request being serviced this cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      idx_d        = idx_q;
      cur_c        = req_q;
      cur_idx_c    = idx_q;
      ram_en_c     = 1'b0;
      ram_we_c     = 4'b0000;
      resp_mask_d  = resp_mask_q;
      resp_err_d   = resp_err_q;
      io_stall     = 1'b0;

      case (state_q)
         DMEM_ST_IDLE: begin
            cur_c     = req_c;
            cur_idx_c = idx_c;
            io_stall  = io_req_valid;
            if (io_req_valid) begin
               req_d   = req_c;
               idx_d   = idx_c;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY <= 1) ? DMEM_ST_RESP : DMEM_ST_WAIT;
            end
         end
         DMEM_ST_WAIT: begin
            io_stall = 1'b1;
            cnt_d    = cnt_q - DMEM_CNT_WIDTH'(1);
            if (cnt_q <= DMEM_CNT_WIDTH'(1)) begin
               state_d = DMEM_ST_RESP;
            end
         end
         DMEM_ST_RESP: begin
            state_d = DMEM_ST_IDLE;
         end
         default: begin
            state_d = DMEM_ST_IDLE;
         end
      endcase

      if (state_d == DMEM_ST_RESP) begin
         ram_en_c    = 1'b1;
         ram_we_c    = cur_c.mask & {4{cur_c.wen & ~(cur_c.range_err | cur_c.mis_err)}};
         resp_mask_d = cur_c.mask;
         resp_err_d  = cur_c.range_err | cur_c.mis_err;
      end

      ready_d      = (state_d == DMEM_ST_IDLE);
      resp_valid_d = (state_d == DMEM_ST_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= DMEM_ST_IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         idx_q        <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_mask_q  <= 4'b0000;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         idx_q        <= idx_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_mask_q  <= resp_mask_d;
         resp_err_q   <= resp_err_d;
      end
   end

   dmem_sram_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .en    (ram_en_c),
      .zero  (cur_c.range_err),
      .addr  (cur_idx_c),
      .we    (ram_we_c),
      .wdata (cur_c.wdata),
      .rdata (ram_rdata)
   );

   assign io_req_ready  = ready_q;
   assign io_resp_valid = resp_valid_q;
   assign io_resp_rdata = ram_rdata;
   assign io_resp_mask  = resp_mask_q;
   assign io_resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: two responders (LATENCY 2 and 3) driven by the same request stream.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_wen;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;

   logic        rdy2, v2, e2, st2;
   logic [31:0] rd2;
   logic [3:0]  m2;
   logic        rdy3, v3, e3, st3;
   logic [31:0] rd3;
   logic [3:0]  m3;

   int          checks;
   int          errors;

   int          lat2, lat3, stall2_cyc;
   logic        rdy_wait2;
   logic [31:0] r2_data, r3_data;
   logic [3:0]  r2_mask, r3_mask;
   logic        r2_err, r3_err;

   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .io_req_valid(req_valid), .io_req_ready(rdy2),
      .io_req_addr(req_addr), .io_req_wen(req_wen), .io_req_size(req_size),
      .io_req_wdata(req_wdata), .io_resp_valid(v2), .io_resp_rdata(rd2),
      .io_resp_mask(m2), .io_resp_err(e2), .io_stall(st2)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .io_req_valid(req_valid), .io_req_ready(rdy3),
      .io_req_addr(req_addr), .io_req_wen(req_wen), .io_req_size(req_size),
      .io_req_wdata(req_wdata), .io_resp_valid(v3), .io_resp_rdata(rd3),
      .io_resp_mask(m3), .io_resp_err(e3), .io_stall(st3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One transaction on both DUTs; lat is counted in negedge samples after the acceptance edge.
   task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] sz,
                         input logic [31:0] wd);
      bit got2, got3;
      got2 = 0; got3 = 0; lat2 = 99; lat3 = 99; stall2_cyc = 0; rdy_wait2 = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz; req_wdata = wd;
      #1;
      if (st2) stall2_cyc++;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 20 && !(got2 && got3); k++) begin
         @(negedge clk);
         if (k == 1) rdy_wait2 = rdy2;
         if (!got2) begin
            if (v2) begin
               got2 = 1; lat2 = k; r2_data = rd2; r2_mask = m2; r2_err = e2;
            end else if (st2) stall2_cyc++;
         end
         if (!got3 && v3) begin
            got3 = 1; lat3 = k; r3_data = rd3; r3_mask = m3; r3_err = e3;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_word_store_load();
      do_req(32'h0001_0000, 1'b1, 2'd2, 32'hCAFE_F00D);
      do_req(32'h0001_0008, 1'b1, 2'd2, 32'hDEAD_BEEF);
      checks++; if (lat2 !== 2) begin errors++; $display("FAIL sw_lat2 got %0d exp 2", lat2); end
      checks++; if (lat3 !== 3) begin errors++; $display("FAIL sw_lat3 got %0d exp 3", lat3); end
      checks++; if (r2_mask !== 4'b1111) begin errors++; $display("FAIL sw_mask got %b exp 1111", r2_mask); end
      checks++; if (r2_err !== 1'b0) begin errors++; $display("FAIL sw_err got %b exp 0", r2_err); end
      checks++; if (stall2_cyc !== 2) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 2", stall2_cyc); end
      checks++; if (rdy_wait2 !== 1'b0) begin errors++; $display("FAIL ready_in_wait got %b exp 0", rdy_wait2); end
      do_req(32'h0001_0008, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata2 got %h exp deadbeef", r2_data); end
      checks++; if (r3_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata3 got %h exp deadbeef", r3_data); end
      checks++; if (r3_mask !== 4'b1111) begin errors++; $display("FAIL lw_mask3 got %b exp 1111", r3_mask); end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", rdy2); end
      checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", v2); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rd2); end
      checks++; if (m2 !== 4'b0000) begin errors++; $display("FAIL rst_mask2 got %b exp 0000", m2); end
      checks++; if (m3 !== 4'b0000) begin errors++; $display("FAIL rst_mask3 got %b exp 0000", m3); end
      checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", e2); end
      checks++; if (st2 !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", st2); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_byte_store();
      do_req(32'h0001_0009, 1'b1, 2'd0, 32'h0000_AB00);
      checks++; if (r2_mask !== 4'b0010) begin errors++; $display("FAIL sb_mask got %b exp 0010", r2_mask); end
      checks++; if (r2_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_prewrite got %h exp deadbeef", r2_data); end
      do_req(32'h0001_0008, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_data !== 32'hDEAD_ABEF) begin errors++; $display("FAIL sb_readback2 got %h exp deadabef", r2_data); end
      checks++; if (r3_data !== 32'hDEAD_ABEF) begin errors++; $display("FAIL sb_readback3 got %h exp deadabef", r3_data); end
   endtask

   task automatic test_half_load();
      do_req(32'h0001_000A, 1'b0, 2'd1, 32'h0);
      checks++; if (r2_mask !== 4'b1100) begin errors++; $display("FAIL lh_mask got %b exp 1100", r2_mask); end
      checks++; if (r2_data !== 32'hDEAD_ABEF) begin errors++; $display("FAIL lh_rdata got %h exp deadabef", r2_data); end
      checks++; if (r2_err !== 1'b0) begin errors++; $display("FAIL lh_err got %b exp 0", r2_err); end
   endtask

   task automatic test_out_of_range();
      do_req(32'h0002_0000, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", r2_err); end
      checks++; if (r2_data !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", r2_data); end
      checks++; if (lat2 !== 2) begin errors++; $display("FAIL oor_lat2 got %0d exp 2", lat2); end
      checks++; if (lat3 !== 3) begin errors++; $display("FAIL oor_lat3 got %0d exp 3", lat3); end
      do_req(32'h0002_0000, 1'b1, 2'd2, 32'h1111_1111);
      checks++; if (r3_err !== 1'b1) begin errors++; $display("FAIL oor_sw_err got %b exp 1", r3_err); end
      do_req(32'h0001_0000, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_no_write got %h exp cafef00d", r2_data); end
      checks++; if (r2_err !== 1'b0) begin errors++; $display("FAIL inrange_err got %b exp 0", r2_err); end
   endtask

   task automatic test_reset_in_wait();
      bit seen;
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0001_0000; req_wen = 1'b1; req_size = 2'd2;
      req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      #1;
      checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL rwait_ready got %b exp 1", rdy3); end
      checks++; if (st3 !== 1'b0) begin errors++; $display("FAIL rwait_stall got %b exp 0", st3); end
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (v2 || v3) seen = 1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rwait_no_resp got %b exp 0", seen); end
      do_req(32'h0001_0000, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rwait_old2 got %h exp cafef00d", r2_data); end
      checks++; if (r3_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rwait_old3 got %h exp cafef00d", r3_data); end
   endtask

   task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
      do_req(32'h0001_0001, 1'b0, 2'd1, 32'h0);
      checks++; if (r2_err !== 1'b1) begin errors++; $display("FAIL mis_lh_err got %b exp 1", r2_err); end
      checks++; if (r2_mask !== 4'b0000) begin errors++; $display("FAIL mis_lh_mask got %b exp 0000", r2_mask); end
      do_req(32'h0001_0002, 1'b1, 2'd2, 32'h5555_5555);
      checks++; if (r3_err !== 1'b1) begin errors++; $display("FAIL mis_sw_err got %b exp 1", r3_err); end
      do_req(32'h0001_0000, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_no_write got %h exp cafef00d", r2_data); end
`else
      do_req(32'h0001_0001, 1'b0, 2'd1, 32'h0);
      checks++; if (r2_mask !== 4'b0011) begin errors++; $display("FAIL mis_lh_mask got %b exp 0011", r2_mask); end
      checks++; if (r2_err !== 1'b0) begin errors++; $display("FAIL mis_lh_err got %b exp 0", r2_err); end
      do_req(32'h0001_0002, 1'b0, 2'd2, 32'h0);
      checks++; if (r2_mask !== 4'b1111) begin errors++; $display("FAIL mis_lw_mask got %b exp 1111", r2_mask); end
      checks++; if (r2_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_lw_rdata got %h exp cafef00d", r2_data); end
`endif
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = '0; req_wdata = '0;
      #22;
      @(negedge clk) rst = 1'b0;
      test_word_store_load();
      test_reset();
      test_byte_store();
      test_half_load();
      test_out_of_range();
      test_reset_in_wait();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
